alu_exec: RTL and testbench

- Execute-stage sequencer sitting directly upstream of the combinational 32-bit ALU.
- Accepts an instruction's operands and opcode via valid/ready and registers them onto the ALU inputs.
- Captures the ALU result and zero/negative flags one cycle later.
- Implements unsigned divide and remainder (op 14/15), which the ALU lacks, with a 32-cycle restoring divider.
- Delivers every result through one registered output with a single-cycle valid pulse.

---
 rtl/alu_exec.sv | 118 +++++++++++
 tb/tb_alu_exec.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec.sv
// Execute-stage sequencer: registers operands onto an external combinational ALU,
// captures its result/flags, and adds a 32-cycle restoring unsigned divider.
`timescale 1ns/1ps

module alu_exec #(
  parameter logic [4:0] OP_DIVU = 5'd14,
  parameter logic [4:0] OP_REMU = 5'd15
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a_in,
  input  logic [31:0] b_in,
  input  logic [7:0]  op_in,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [7:0]  alu_op,
  input  logic [31:0] alu_c,
  input  logic        alu_zero,
  input  logic        alu_neg,
  output logic [31:0] result,
  output logic        flag_zero,
  output logic        flag_negative,
  output logic        out_valid,
  output logic        busy
);

  // state | meaning
  // IDLE  | ready for a new instruction
  // EXEC  | ALU settling on registered operands; capture at edge
  // DIV   | restoring divide, one quotient bit per cycle (count 0..31)
  // DONE  | out_valid pulse
  typedef enum logic [1:0] {IDLE, EXEC, DIV, DONE} state_t;

  state_t      state, state_nxt;
  logic [31:0] quo, rem;
  logic [4:0]  count;

  logic        is_div_in;
  logic [32:0] shifted;
  logic [33:0] trial;
  logic        borrow;
  logic [31:0] quo_nxt, rem_nxt, div_val;

  assign is_div_in = (op_in[4:0] == OP_DIVU) || (op_in[4:0] == OP_REMU);

  // Keep rem[31] in the shifted partial remainder so divisors above 2^31 stay exact.
  assign shifted = {rem, quo[31]};
  assign trial   = {1'b0, shifted} - {2'b00, alu_b};
  assign borrow  = trial[33];
  assign rem_nxt = borrow ? shifted[31:0] : trial[31:0];
  assign quo_nxt = {quo[30:0], ~borrow};
  assign div_val = (alu_op[4:0] == OP_REMU) ? rem_nxt : quo_nxt;

  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign out_valid = (state == DONE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (in_valid) state_nxt = is_div_in ? DIV : EXEC;
      EXEC: state_nxt = DONE;
      DIV:  if (count == 5'd31) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state         <= IDLE;
      alu_a         <= '0;
      alu_b         <= '0;
      alu_op        <= '0;
      result        <= '0;
      flag_zero     <= 1'b0;
      flag_negative <= 1'b0;
      quo           <= '0;
      rem           <= '0;
      count         <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (in_valid) begin
            alu_a  <= a_in;
            alu_b  <= b_in;
            alu_op <= op_in;
            if (is_div_in) begin
              quo   <= a_in;
              rem   <= '0;
              count <= '0;
            end
          end
        end
        EXEC: begin
          result        <= alu_c;
          flag_zero     <= alu_zero;
          flag_negative <= alu_neg;
        end
        DIV: begin
          quo   <= quo_nxt;
          rem   <= rem_nxt;
          count <= count + 5'd1;
          if (count == 5'd31) begin
            result        <= div_val;
            flag_zero     <= (div_val == 32'd0);
            flag_negative <= div_val[31];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec.sv
// Scoreboard bench for alu_exec: directed vectors, a small ALU model on the
// alu_* bus, and a monitor that checks every out_valid pulse and its latency.
`timescale 1ns/1ps

module tb_alu_exec;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a_in = '0, b_in = '0;
  logic [7:0]  op_in = '0;
  logic [31:0] alu_a, alu_b, alu_c;
  logic [7:0]  alu_op;
  logic        alu_zero, alu_neg;
  logic [31:0] result;
  logic        flag_zero, flag_negative, out_valid, busy;

  alu_exec dut (
    .clk(clk), .resetn(resetn),
    .in_valid(in_valid), .in_ready(in_ready),
    .a_in(a_in), .b_in(b_in), .op_in(op_in),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_c(alu_c), .alu_zero(alu_zero), .alu_neg(alu_neg),
    .result(result), .flag_zero(flag_zero), .flag_negative(flag_negative),
    .out_valid(out_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  // ALU stand-in: add(0), sub(2), cmp(8), everything else returns 0
  always_comb begin
    alu_c = 32'd0;
    case (alu_op[4:0])
      5'd0: alu_c = alu_a + alu_b;
      5'd2: alu_c = alu_a - alu_b;
      5'd8: alu_c = alu_a - alu_b;
      default: alu_c = 32'd0;
    endcase
  end
  assign alu_zero = (alu_c == 32'd0);
  assign alu_neg  = alu_c[31];

  typedef struct {
    logic [31:0] res;
    logic        z;
    logic        n;
    int          due;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (resetn && out_valid) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL spurious_out_valid: got result %h with nothing expected (t=%0t)", result, $time);
      end else begin
        e = q.pop_front();
        chk("result", result, e.res);
        chk("flag_zero", {31'd0, flag_zero}, {31'd0, e.z});
        chk("flag_negative", {31'd0, flag_negative}, {31'd0, e.n});
        chk("latency_cycle", cyc, e.due);
      end
    end
  end

  // Present an instruction at a negedge, wait for in_ready, record the accept
  // cycle, and return just after the accept edge.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [7:0] op,
                       input logic [31:0] er, input logic ez, input logic en,
                       input int lat, input bit push, input bit hold, output int acc);
    int n;
    exp_t e;
    @(negedge clk);
    a_in = a; b_in = b; op_in = op; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: in_ready got 0 want 1");
    end
    acc = cyc;
    if (push) begin
      e.res = er; e.z = ez; e.n = en; e.due = cyc + lat;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: got %0d pending want 0", q.size());
      q.delete();
    end
  endtask

  typedef struct {
    logic [31:0] a, b;
    logic [7:0]  op;
    logic [31:0] r;
    logic        z, n;
    int          lat;
  } vec_t;

  initial begin
    vec_t vecs[10];
    int acc, prev;

    vecs[0] = '{32'h7FFF_FFFF, 32'd1,    8'd0,  32'h8000_0000, 1'b0, 1'b1, 2};
    vecs[1] = '{32'h1234,      32'h1234, 8'd8,  32'd0,         1'b1, 1'b0, 2};
    vecs[2] = '{32'd3,         32'd5,    8'd2,  32'hFFFF_FFFE, 1'b0, 1'b1, 2};
    vecs[3] = '{32'd5,         32'd6,    8'd20, 32'd0,         1'b1, 1'b0, 2};
    vecs[4] = '{32'd100,       32'd7,    8'd14, 32'd14,        1'b0, 1'b0, 33};
    vecs[5] = '{32'd100,       32'd7,    8'd15, 32'd2,         1'b0, 1'b0, 33};
    vecs[6] = '{32'hFFFF_FFFF, 32'd1,    8'd14, 32'hFFFF_FFFF, 1'b0, 1'b1, 33};
    vecs[7] = '{32'd42,        32'd0,    8'd14, 32'hFFFF_FFFF, 1'b0, 1'b1, 33};
    vecs[8] = '{32'd42,        32'd0,    8'd15, 32'd42,        1'b0, 1'b0, 33};
    vecs[9] = '{32'hFFFF_FFFF, 32'h8000_0001, 8'd15, 32'h7FFF_FFFE, 1'b0, 1'b0, 33};

    repeat (2) @(negedge clk);
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_result", result, 32'd0);
    resetn = 1'b1;

    for (int i = 0; i < 10; i++) begin
      issue(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].r, vecs[i].z, vecs[i].n,
            vecs[i].lat, 1'b1, 1'b0, acc);
      drain();
    end

    // upper opcode bits pass straight through to the ALU
    issue(32'd1, 32'd2, 8'hA0, 32'd3, 1'b0, 1'b0, 2, 1'b1, 1'b0, acc);
    chk("alu_op_passthru", {24'd0, alu_op}, 32'h0000_00A0);
    chk("alu_a_latched", alu_a, 32'd1);
    chk("alu_b_latched", alu_b, 32'd2);
    drain();

    // in_valid held high across back-to-back adds: one accept every 3 cycles
    issue(32'd1, 32'd1, 8'd0, 32'd2, 1'b0, 1'b0, 2, 1'b1, 1'b1, prev);
    issue(32'd2, 32'd2, 8'd0, 32'd4, 1'b0, 1'b0, 2, 1'b1, 1'b1, acc);
    chk("issue_interval_1", acc - prev, 32'd3);
    prev = acc;
    issue(32'd10, 32'd20, 8'd0, 32'd30, 1'b0, 1'b0, 2, 1'b1, 1'b1, acc);
    chk("issue_interval_2", acc - prev, 32'd3);
    prev = acc;
    issue(32'd0, 32'd0, 8'd0, 32'd0, 1'b1, 1'b0, 2, 1'b1, 1'b0, acc);
    chk("issue_interval_3", acc - prev, 32'd3);
    drain();

    // divide ignores new inputs and keeps in_ready low / busy high for 33 cycles
    issue(32'd1000, 32'd10, 8'd14, 32'd100, 1'b0, 1'b0, 33, 1'b1, 1'b0, acc);
    for (int i = 0; i < 33; i++) begin
      @(negedge clk);
      if (i == 0) begin
        a_in = 32'd777; op_in = 8'd0; in_valid = 1'b1;
      end
      if (in_ready !== 1'b0 || busy !== 1'b1) begin
        chk("div_in_ready", {31'd0, in_ready}, 32'd0);
        chk("div_busy", {31'd0, busy}, 32'd1);
      end
      if (i == 32) in_valid = 1'b0;
    end
    chk("div_hold_in_ready", {31'd0, in_ready}, 32'd0);
    drain();

    // asynchronous reset at divide count 10 abandons the operation
    issue(32'd200, 32'd3, 8'd14, 32'd0, 1'b0, 1'b0, 33, 1'b0, 1'b0, acc);
    repeat (10) @(posedge clk);
    #2 resetn = 1'b0;
    #1;
    chk("rst_result", result, 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_op", {24'd0, alu_op}, 32'd0);
    chk("rst_flags", {30'd0, flag_zero, flag_negative}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    repeat (40) @(negedge clk);

    issue(32'd5, 32'd6, 8'd0, 32'd11, 1'b0, 1'b0, 2, 1'b1, 1'b0, acc);
    drain();
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete (total=%0d bad=%0d)", total, bad);
    $fatal(1);
  end

endmodule
